// File: rtl/vga_cell_sampler.sv
// vga_cell_sampler: locks onto a VGA timing stream and samples the
// centre pixel of every board cell, classifying its colour.
module vga_cell_sampler #(
    parameter int ANCHO    = 640,
    parameter int ALTO     = 480,
    parameter int FILAS    = 8,
    parameter int COLUMNAS = 8,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       blank_n,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       locked,
    output logic       cell_valid,
    output logic       frame_done,
    output logic [2:0] cell_row,
    output logic [2:0] cell_col,
    output logic [2:0] cell_code,
    output logic       err_line,
    output logic       err_frame
);

    localparam int H_TOTAL = ANCHO + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ALTO + V_FP + V_SYNC + V_BP;
    localparam int H_ACT   = H_SYNC + H_BP;
    localparam int V_ACT   = V_SYNC + V_BP;
    localparam int CELL_W  = ANCHO / COLUMNAS;
    localparam int CELL_H  = ALTO / FILAS;

    localparam logic [9:0] H_END = 10'(H_TOTAL);
    localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
    localparam logic [9:0] CMAX  = 10'h3FF;

    typedef enum logic [1:0] {
        HUNT,
        ALIGN,
        VERIFY,
        LOCKED
    } state_t;

    state_t     state;
    state_t     state_n;
    logic       h_prev;
    logic       v_prev;
    logic       h_rise;
    logic       v_rise;
    logic       line_err;
    logic       frame_err;
    logic       col_hit;
    logic       row_hit;
    logic       sample;
    logic [2:0] col_idx;
    logic [2:0] row_idx;
    logic [2:0] code;

    assign h_rise = h_sync & ~h_prev;
    assign v_rise = h_rise & v_sync & ~v_prev;

    assign line_err  = h_rise && (h_count != H_END)
                       && (state != HUNT);
    assign frame_err = v_rise && (v_count != V_END)
                       && (state == VERIFY || state == LOCKED);

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_prev  <= 1'b0;
            v_prev  <= 1'b0;
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_prev <= h_sync;
            if (h_rise)
                v_prev <= v_sync;
            if (h_rise)
                h_count <= 10'd1;
            else if (h_count != CMAX)
                h_count <= h_count + 10'd1;
            if (v_rise)
                v_count <= '0;
            else if (h_rise && v_count != CMAX)
                v_count <= v_count + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= HUNT;
        else
            state <= state_n;
    end

    // Any timing error overrides the normal acquisition progress.
    always_comb begin
        state_n = state;
        unique case (state)
            HUNT:    if (h_rise) state_n = ALIGN;
            ALIGN:   if (v_rise) state_n = VERIFY;
            VERIFY:  if (v_rise) state_n = LOCKED;
            LOCKED:  state_n = LOCKED;
            default: state_n = HUNT;
        endcase
        if (line_err || frame_err)
            state_n = HUNT;
    end

    always_comb begin
        col_hit = 1'b0;
        col_idx = '0;
        for (int c = 0; c < COLUMNAS; c++) begin
            if (h_count == 10'(H_ACT + CELL_W * c + CELL_W / 2)) begin
                col_hit = 1'b1;
                col_idx = 3'(c);
            end
        end
    end

    always_comb begin
        row_hit = 1'b0;
        row_idx = '0;
        for (int r = 0; r < FILAS; r++) begin
            if (v_count == 10'(V_ACT + CELL_H * r + CELL_H / 2)) begin
                row_hit = 1'b1;
                row_idx = 3'(r);
            end
        end
    end

    always_comb begin
        code = 3'd7;
        case ({red, green, blue})
            24'h5C4033: code = 3'd0;
            24'hFFFF00: code = 3'd1;
            24'h00FF00: code = 3'd2;
            24'h00BA00: code = 3'd3;
            24'hFF0000: code = 3'd4;
            24'h0000FF: code = 3'd5;
            default:    code = 3'd7;
        endcase
        if (!blank_n)
            code = 3'd7;
    end

    // An error edge never yields a sample, even if the stale count matches.
    assign sample = (state == LOCKED) && col_hit && row_hit
                    && !line_err && !frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_valid <= 1'b0;
            frame_done <= 1'b0;
            cell_row   <= '0;
            cell_col   <= '0;
            cell_code  <= '0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            cell_valid <= sample;
            frame_done <= sample
                          && (row_idx == 3'(FILAS - 1))
                          && (col_idx == 3'(COLUMNAS - 1));
            err_line   <= line_err;
            err_frame  <= frame_err;
            if (sample) begin
                cell_row  <= row_idx;
                cell_col  <= col_idx;
                cell_code <= code;
            end
        end
    end

endmodule
